matrix_out_serializer: RTL and testbench

MATRIX_OUT_SERIALIZER -- requirements
Module: matrix_out_serializer

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_out_serializer_if.sv | 28 ++
 rtl/vec_fifo2.sv | 51 +++++
 rtl/matrix_out_serializer.sv | 120 ++++++++++++
 tb/tb_matrix_out_serializer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared widths, FSM state encoding and word-select helper for the matrix output path.
package matrix_pkg;

    localparam int unsigned WORD_W        = 64;
    localparam int unsigned VEC_W         = 256;
    localparam int unsigned WORDS_PER_VEC = 4;
    localparam int unsigned IDX_W         = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // Word k of a vector is bits [64k+63:64k]; word 0 is the least significant.
    function automatic logic [WORD_W-1:0] word_of(input logic [VEC_W-1:0] vec,
                                                  input logic [IDX_W-1:0] idx);
        return vec[WORD_W*int'(idx) +: WORD_W];
    endfunction

endpackage

// File: rtl/matrix_out_serializer_if.sv
// Upstream vector handshake plus downstream word strobe of the serializer.
// prehash_in exists only when MATSER_XOR_EN is defined.
interface matrix_out_serializer_if;
    import matrix_pkg::*;

    logic               vec_valid;
    logic [VEC_W-1:0]   vec_in;
    logic               vec_ready;
`ifdef MATSER_XOR_EN
    logic [VEC_W-1:0]   prehash_in;
`endif
    logic               we_out;
    logic [WORD_W-1:0]  dout;
    logic               busy;

`ifdef MATSER_XOR_EN
    modport master (output vec_valid, vec_in, prehash_in,
                    input  vec_ready, we_out, dout, busy);
    modport slave  (input  vec_valid, vec_in, prehash_in,
                    output vec_ready, we_out, dout, busy);
`else
    modport master (output vec_valid, vec_in,
                    input  vec_ready, we_out, dout, busy);
    modport slave  (input  vec_valid, vec_in,
                    output vec_ready, we_out, dout, busy);
`endif

endinterface

// File: rtl/vec_fifo2.sv
// Two-entry vector FIFO; a push into a full buffer is dropped even if a pop coincides.
module vec_fifo2
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [VEC_W-1:0]  wdata,
    output logic              full_c,
    output logic              empty_c,
    output logic [1:0]        count,
    output logic [VEC_W-1:0]  head_c
);

    logic [VEC_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c    = (count == 2'd2);
    assign empty_c   = (count == 2'd0);
    assign push_ok_c = push & ~full_c;
    assign pop_ok_c  = pop & ~empty_c;
    assign head_c    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok_c) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push_ok_c && !pop_ok_c) begin
                count <= count + 2'd1;
            end else if (!push_ok_c && pop_ok_c) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_out_serializer.sv
// Buffers 256-bit matrix-product vectors and emits each as four 64-bit words, LSW first,
// with GAP_CYCLES idle cycles between bursts. MATSER_XOR_EN stores vec_in ^ prehash_in.
module matrix_out_serializer
    import matrix_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    matrix_out_serializer_if.slave   bus
);

    localparam int unsigned GAP_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_VEC - 1);

    ser_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [GAP_W-1:0]  gap_cnt;

    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              empty_c;
    logic [1:0]        count;
    logic [1:0]        occ_next_c;
    logic [VEC_W-1:0]  head_c;
    logic [VEC_W-1:0]  wdata_c;
    logic              gap_done_c;
    logic              busy_next_c;

`ifdef MATSER_XOR_EN
    assign wdata_c = bus.vec_in ^ bus.prehash_in;
`else
    assign wdata_c = bus.vec_in;
`endif

    assign push_c     = bus.vec_valid & bus.vec_ready & ~full_c;
    assign pop_c      = (state == BURST) && (idx == LAST_IDX);
    assign gap_done_c = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES));

    // Occupancy after this edge drives the registered ready flag.
    always_comb begin
        occ_next_c = count;
        if (push_c && !pop_c) begin
            occ_next_c = count + 2'd1;
        end else if (!push_c && pop_c) begin
            occ_next_c = count - 2'd1;
        end
    end

    // The FSM falls to IDLE only when there is nothing left to send.
    assign busy_next_c = (occ_next_c != 2'd0) ||
                         !(((state == IDLE) || gap_done_c) && empty_c);

    vec_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (wdata_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (count),
        .head_c  (head_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            gap_cnt       <= '0;
            bus.we_out    <= 1'b0;
            bus.dout      <= '0;
            bus.vec_ready <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.vec_ready <= (occ_next_c < 2'd2);
            bus.busy      <= busy_next_c;
            case (state)
                IDLE: begin
                    if (!empty_c) begin
                        state      <= BURST;
                        idx        <= '0;
                        bus.we_out <= 1'b1;
                        bus.dout   <= word_of(head_c, '0);
                    end
                end
                BURST: begin
                    if (idx == LAST_IDX) begin
                        state      <= GAP;
                        gap_cnt    <= GAP_W'(1);
                        bus.we_out <= 1'b0;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        bus.dout <= word_of(head_c, idx + IDX_W'(1));
                    end
                end
                GAP: begin
                    if (gap_done_c) begin
                        if (!empty_c) begin
                            state      <= BURST;
                            idx        <= '0;
                            bus.we_out <= 1'b1;
                            bus.dout   <= word_of(head_c, '0);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.we_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_out_serializer.sv
// Bench for matrix_out_serializer: GAP_CYCLES=1 and GAP_CYCLES=3 instances share stimulus
// and are checked every cycle against a burst-schedule model of accepted vectors.
module tb_matrix_out_serializer;
    import matrix_pkg::*;

    localparam int NMAX = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vv;
    logic [255:0] vin;
    logic [255:0] pre;

    always #5 clk = ~clk;

    matrix_out_serializer_if bus0 ();
    matrix_out_serializer_if bus1 ();

    assign bus0.vec_valid = vv;
    assign bus0.vec_in    = vin;
    assign bus1.vec_valid = vv;
    assign bus1.vec_in    = vin;
`ifdef MATSER_XOR_EN
    assign bus0.prehash_in = pre;
    assign bus1.prehash_in = pre;
`endif

    matrix_out_serializer #(.GAP_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    matrix_out_serializer #(.GAP_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int           gapc [2] = '{1, 3};
    logic [255:0] e_dat   [2][NMAX];
    int           e_acc   [2][NMAX];
    int           e_start [2][NMAX];
    int           e_n     [2];
    logic         rdy_m   [2];
    logic [63:0]  last_d  [2];
    int           cyc;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [255:0] rand_vec();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Vectors accepted but not yet popped (pop lands four edges after the burst starts).
    function automatic int occ_at(int g, int e);
        int n = 0;
        for (int i = 0; i < e_n[g]; i++)
            if (e_acc[g][i] <= e && e_start[g][i] + 4 > e) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d observed %h expected %h", tag, g, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input int g, input logic rdy, input logic we,
                             input logic [63:0] d, input logic bsy);
        if (g == 0) begin
            chk("vec_ready", 0, 64'(bus0.vec_ready), 64'(rdy));
            chk("we_out",    0, 64'(bus0.we_out),    64'(we));
            chk("dout",      0, bus0.dout,           d);
            chk("busy",      0, 64'(bus0.busy),      64'(bsy));
        end else begin
            chk("vec_ready", 1, 64'(bus1.vec_ready), 64'(rdy));
            chk("we_out",    1, 64'(bus1.we_out),    64'(we));
            chk("dout",      1, bus1.dout,           d);
            chk("busy",      1, 64'(bus1.busy),      64'(bsy));
        end
    endtask

    // One clock: drive inputs, record accepts into the model, check both DUTs after the edge.
    task automatic tick(input logic v, input logic [255:0] d, input logic [255:0] p);
        vv  = v;
        vin = d;
        pre = p;
        for (int g = 0; g < 2; g++) begin
            if (v && rdy_m[g] && e_n[g] < NMAX) begin
                int st;
                st = cyc + 2;
                if (e_n[g] > 0 && e_start[g][e_n[g]-1] + 4 + gapc[g] > st)
                    st = e_start[g][e_n[g]-1] + 4 + gapc[g];
`ifdef MATSER_XOR_EN
                e_dat[g][e_n[g]] = d ^ p;
`else
                e_dat[g][e_n[g]] = d;
`endif
                e_acc[g][e_n[g]]   = cyc + 1;
                e_start[g][e_n[g]] = st;
                e_n[g]++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int g = 0; g < 2; g++) begin
            logic we_e;
            logic busy_e;
            int   occ;
            occ    = occ_at(g, cyc);
            rdy_m[g] = (occ < 2);
            we_e   = 1'b0;
            busy_e = (occ > 0);
            for (int i = 0; i < e_n[g]; i++) begin
                int s;
                s = e_start[g][i];
                if (s <= cyc && cyc <= s + 3) begin
                    logic [255:0] t;
                    t = e_dat[g][i];
                    we_e      = 1'b1;
                    last_d[g] = t[64*(cyc-s) +: 64];
                end
                if (s <= cyc && cyc <= s + 3 + gapc[g]) busy_e = 1'b1;
            end
            check_all(g, rdy_m[g], we_e, last_d[g], busy_e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, rand_vec(), rand_vec());
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #1;
        rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            e_n[g]    = 0;
            rdy_m[g]  = 1'b0;
            last_d[g] = '0;
            check_all(g, 1'b0, 1'b0, 64'd0, 1'b0);
        end
        vv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [255:0] v;
        vv  = 1'b0;
        vin = '0;
        pre = '0;
        cyc = 0;
        do_reset();

        // Single vector with word k = k+1.
        idle(1);
        v = {64'd4, 64'd3, 64'd2, 64'd1};
        tick(1'b1, v, '0);
        tick(1'b0, '0, '0);
        chk("single_w0", 0, bus0.dout, 64'd1);
        idle(12);

        // Back-to-back traffic: valid held high, fills the buffer and exercises full+pop.
        for (int i = 0; i < 14; i++) tick(1'b1, rand_vec(), rand_vec());
        idle(30);

        // Reset after word 1 of a burst, then restart from word 0.
        do_reset();
        idle(1);
        tick(1'b1, rand_vec(), rand_vec());
        idle(2);
        chk("mid_we", 0, 64'(bus0.we_out), 64'd1);
        do_reset();
        idle(1);
        tick(1'b1, rand_vec(), rand_vec());
        idle(12);

`ifdef MATSER_XOR_EN
        tick(1'b1, '1, {4{64'hAAAA_AAAA_AAAA_AAAA}});
        tick(1'b0, '0, '0);
        chk("xor_w0", 0, bus0.dout, 64'h5555_5555_5555_5555);
        idle(10);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 1)), rand_vec(), rand_vec());
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
